// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Handshake and operand/result bundle for the bit-serial adder.
//   master : requester side (drives start/a/b/cin, observes results)
//   slave  : adder side (observes request, drives sum/cout/busy/done)
//   Signals:
//     start  request, sampled by the adder only while idle
//     a, b   WIDTH-bit operands
//     cin    carry-in
//     sum    WIDTH-bit result, held from done until the next accept
//     cout   final carry-out, held with sum
//     busy   adder is stepping through bits
//     done   one-cycle completion pulse
//     ovf    signed overflow flag (only when SERIAL_ADD_OVF_EN is defined)
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input sum, cout, busy, done, ovf);
  modport slave  (input start, a, b, cin, output sum, cout, busy, done, ovf);
`else
  modport master (output start, a, b, cin, input sum, cout, busy, done);
  modport slave  (input start, a, b, cin, output sum, cout, busy, done);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder computing a + b + cin LSB-first, one bit per
//   clock, through a single 1-bit full adder (fa). The carry is registered and
//   fed back into fa on the following cycle. start/done handshake.
//   Parameters:
//     WIDTH  operand/result width, >= 2
//   Ports:
//     clk    rising-edge clock
//     rst    asynchronous active-high reset (aborts any add in progress)
//     bus    serial_adder_if.slave: start, a, b, cin in; sum, cout, busy, done
//            (and ovf) out
//   Optional feature macro:
//     SERIAL_ADD_OVF_EN  adds the ovf output (two's-complement overflow,
//                        carry-into-MSB XOR carry-out-of-MSB)
//   Timing: accept at edge 0, one bit per edge 1..WIDTH, done high for the
//   cycle after edge WIDTH, idle again after edge WIDTH+1.

module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 sum bits produced so far; the last bit comes straight
  // from fa when the result is committed.
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_cout;
  logic             accept;
  logic             last;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  fa u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign accept = (state_q == IDLE) && bus.start;
  assign last   = (state_q == RUN) && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- stage: operand capture / bit-serial step / result commit ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= bus.a;
      b_sr  <= bus.b;
      carry <= bus.cin;
      cnt   <= '0;
    end else if (state_q == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= (WIDTH-1)'({fa_s, res_sr} >> 1);
      carry  <= fa_cout;
      // Counter parks at LAST on the final step instead of wrapping.
      if (!last) cnt <= cnt + 1'b1;
      if (last) begin
        sum_q  <= {fa_s, res_sr};
        cout_q <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
        // On the final step carry is the carry into the MSB.
        ovf_q  <= carry ^ fa_cout;
`endif
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
